multicycle_control_fsm: RTL and testbench

Multi-cycle sequencing controller for the RV32I core datapath. It takes the 7-bit opcode from the instruction register and steps the shared ALU, register file, PC and the single memory port through fetch, decode, execute, memory and writeback. It generates per-state control strobes, handles the memory ready handshake and counts retired instructions.

---
 rtl/multicycle_control_fsm.sv | 183 ++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle sequencing controller for the RV32I datapath: fetch/decode/execute/memory/writeback.
// Optional build macro ILLEGAL_TRAP_EN freezes the core in TRAP on an illegal opcode.
module multicycle_control_fsm #(
  parameter int INSTRET_WIDTH = 32,
  parameter int BOOT_CYCLES   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [6:0]               instrution_opcode,
  input  logic                     mem_ready,
  input  logic                     branch_taken,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic                     iord,
  output logic                     ir_write,
  output logic                     pc_write,
  output logic                     reg_write,
  output logic [1:0]               alu_src_a,
  output logic [1:0]               alu_src_b,
  output logic [1:0]               aluop,
  output logic                     pc_source,
  output logic [1:0]               memory_to_reg,
  output logic                     branch,
  output logic                     trap,
  output logic [INSTRET_WIDTH-1:0] instret
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam int              BOOT_W    = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
`ifdef ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_LUI, C_AUIPC, C_JAL, C_JALR, C_ILLEGAL
  } op_class_t;

  state_t            state;
  op_class_t         op_class;
  logic [BOOT_W-1:0] boot_cnt;

  always_comb begin
    case (instrution_opcode)
      OP_R:      op_class = C_R;
      OP_I:      op_class = C_I;
      OP_LOAD:   op_class = C_LOAD;
      OP_STORE:  op_class = C_STORE;
      OP_BRANCH: op_class = C_BRANCH;
      OP_LUI:    op_class = C_LUI;
      OP_AUIPC:  op_class = C_AUIPC;
      OP_JAL:    op_class = C_JAL;
      OP_JALR:   op_class = C_JALR;
      default:   op_class = C_ILLEGAL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_BOOT;
      boot_cnt <= '0;
      instret  <= '0;
    end else begin
      case (state)
        S_BOOT:
          if (boot_cnt == BOOT_LAST) state <= S_FETCH;
          else                       boot_cnt <= boot_cnt + BOOT_W'(1);
        S_FETCH:
          if (mem_ready) state <= S_DECODE;
        S_DECODE:
          if (op_class == C_ILLEGAL) begin
`ifdef ILLEGAL_TRAP_EN
            state   <= S_TRAP;
`else
            state   <= S_FETCH;
            instret <= instret + INSTRET_WIDTH'(1);
`endif
          end else begin
            state <= S_EXEC;
          end
        S_EXEC:
          case (op_class)
            C_BRANCH: begin
              state   <= S_FETCH;
              instret <= instret + INSTRET_WIDTH'(1);
            end
            C_LOAD, C_STORE: state <= S_MEM;
            default:         state <= S_WB;
          endcase
        S_MEM:
          if (mem_ready) begin
            if (op_class == C_LOAD) begin
              state <= S_WB;
            end else begin
              state   <= S_FETCH;
              instret <= instret + INSTRET_WIDTH'(1);
            end
          end
        S_WB: begin
          state   <= S_FETCH;
          instret <= instret + INSTRET_WIDTH'(1);
        end
        default: state <= state;
      endcase
    end
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    aluop         = 2'b00;
    pc_source     = 1'b0;
    memory_to_reg = 2'b00;
    branch        = 1'b0;
    trap          = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_EXEC:
        case (op_class)
          C_R:     begin alu_src_a = 2'b00; alu_src_b = 2'b00; aluop = 2'b10; end
          C_I:     begin alu_src_a = 2'b00; alu_src_b = 2'b01; aluop = 2'b11; end
          C_LUI:   begin alu_src_a = 2'b11; alu_src_b = 2'b01; end
          C_AUIPC: begin alu_src_a = 2'b01; alu_src_b = 2'b01; end
          C_LOAD, C_STORE: alu_src_b = 2'b01;
          C_BRANCH: begin
            aluop     = 2'b01;
            branch    = 1'b1;
            pc_source = 1'b1;
            pc_write  = branch_taken;
          end
          C_JAL:   begin pc_source = 1'b1; pc_write = 1'b1; end
          C_JALR:  begin alu_src_b = 2'b01; pc_write = 1'b1; end
          default: ;
        endcase
      S_MEM: begin
        iord      = 1'b1;
        mem_read  = (op_class == C_LOAD);
        mem_write = (op_class == C_STORE);
      end
      S_WB: begin
        reg_write = 1'b1;
        if (op_class == C_LOAD)                            memory_to_reg = 2'b01;
        else if (op_class == C_JAL || op_class == C_JALR)  memory_to_reg = 2'b10;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: trap = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: directed cases plus randomized instruction stream
// compared cycle by cycle against an instruction-level model of the expected control strobes.
module tb_multicycle_control_fsm;

  localparam int IW = 4;
  localparam int BC = 1;

  typedef struct packed {
    logic       mem_read, mem_write, iord, ir_write, pc_write, reg_write;
    logic [1:0] a, b, aluop;
    logic       pc_source;
    logic [1:0] m2r;
    logic       branch, trap;
  } ctrl_t;

  typedef enum {K_R, K_I, K_LOAD, K_STORE, K_BRANCH, K_LUI, K_AUIPC, K_JAL, K_JALR, K_BAD} kind_t;

  logic          clk, rst_n;
  logic [6:0]    instrution_opcode;
  logic          mem_ready, branch_taken;
  logic          mem_read, mem_write, iord, ir_write, pc_write, reg_write;
  logic [1:0]    alu_src_a, alu_src_b, aluop, memory_to_reg;
  logic          pc_source, branch, trap;
  logic [IW-1:0] instret;

  int            total = 0;
  int            bad   = 0;
  logic [IW-1:0] exp_instret = '0;
  logic [6:0]    legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                   7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};

  multicycle_control_fsm #(.INSTRET_WIDTH(IW), .BOOT_CYCLES(BC)) dut (
    .clk(clk), .rst_n(rst_n), .instrution_opcode(instrution_opcode), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .aluop(aluop), .pc_source(pc_source), .memory_to_reg(memory_to_reg),
    .branch(branch), .trap(trap), .instret(instret)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic kind_t kind_of(input logic [6:0] opc);
    for (int i = 0; i < 9; i++)
      if (legal_ops[i] == opc) return kind_t'(i);
    return K_BAD;
  endfunction

  function automatic ctrl_t observed();
    return {mem_read, mem_write, iord, ir_write, pc_write, reg_write, alu_src_a, alu_src_b,
            aluop, pc_source, memory_to_reg, branch, trap};
  endfunction

  task automatic check_ctrl(input string tag, input ctrl_t exp);
    ctrl_t obs;
    obs = observed();
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s ctrl observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_instret(input string tag);
    total++;
    assert (instret === exp_instret) else begin
      bad++;
      $error("FAIL %s instret observed=%0d expected=%0d", tag, instret, exp_instret);
    end
  endtask

  // One clock cycle: called at posedge+1, drives inputs, checks at the falling edge.
  task automatic step(input string tag, input ctrl_t exp, input logic rdy, input logic [6:0] opc,
                      input logic tk);
    mem_ready         = rdy;
    instrution_opcode = opc;
    branch_taken      = tk;
    @(negedge clk);
    check_ctrl(tag, exp);
    check_instret(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic boot_cycles();
    for (int i = 0; i < BC; i++) step("boot", '0, 1'($urandom), 7'($urandom), 1'($urandom));
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    exp_instret = '0;
    @(negedge clk);
    check_ctrl("reset", '0);
    check_instret("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    boot_cycles();
  endtask

  task automatic fetch_phase(input int fw);
    ctrl_t e;
    for (int k = 0; k <= fw; k++) begin
      e = '0;
      e.mem_read = 1'b1; e.a = 2'b10; e.b = 2'b10;
      if (k == fw) begin e.ir_write = 1'b1; e.pc_write = 1'b1; end
      step("fetch", e, 1'(k == fw), 7'($urandom), 1'($urandom));
    end
  endtask

  function automatic ctrl_t decode_ctrl();
    ctrl_t e;
    e = '0; e.a = 2'b01; e.b = 2'b01;
    return e;
  endfunction

  // Whole instruction from the first FETCH cycle through its return to FETCH.
  task automatic do_instr(input logic [6:0] opc, input int fw, input int mw, input logic tk);
    ctrl_t e;
    kind_t k;
    k = kind_of(opc);
    fetch_phase(fw);
    step("decode", decode_ctrl(), 1'($urandom), opc, 1'($urandom));
    if (k == K_BAD) begin
`ifdef ILLEGAL_TRAP_EN
      e = '0; e.trap = 1'b1;
      for (int i = 0; i < 5; i++) step("trap", e, 1'($urandom), 7'($urandom), 1'($urandom));
`else
      exp_instret = exp_instret + IW'(1);
`endif
      return;
    end
    e = '0;
    case (k)
      K_R:      begin e.aluop = 2'b10; end
      K_I:      begin e.b = 2'b01; e.aluop = 2'b11; end
      K_LUI:    begin e.a = 2'b11; e.b = 2'b01; end
      K_AUIPC:  begin e.a = 2'b01; e.b = 2'b01; end
      K_LOAD, K_STORE: e.b = 2'b01;
      K_BRANCH: begin e.aluop = 2'b01; e.branch = 1'b1; e.pc_source = 1'b1; e.pc_write = tk; end
      K_JAL:    begin e.pc_source = 1'b1; e.pc_write = 1'b1; end
      K_JALR:   begin e.b = 2'b01; e.pc_write = 1'b1; end
      default:  ;
    endcase
    step("exec", e, 1'($urandom), opc, (k == K_BRANCH) ? tk : 1'($urandom));
    if (k == K_BRANCH) begin
      exp_instret = exp_instret + IW'(1);
      return;
    end
    if (k == K_LOAD || k == K_STORE) begin
      for (int i = 0; i <= mw; i++) begin
        e = '0;
        e.iord = 1'b1;
        e.mem_read  = (k == K_LOAD);
        e.mem_write = (k == K_STORE);
        step("mem", e, 1'(i == mw), opc, 1'($urandom));
      end
      if (k == K_STORE) begin
        exp_instret = exp_instret + IW'(1);
        return;
      end
    end
    e = '0;
    e.reg_write = 1'b1;
    if (k == K_LOAD)                      e.m2r = 2'b01;
    else if (k == K_JAL || k == K_JALR)   e.m2r = 2'b10;
    step("wb", e, 1'($urandom), opc, 1'($urandom));
    exp_instret = exp_instret + IW'(1);
  endtask

  initial begin
    logic [6:0] opc;
    ctrl_t      e;
    rst_n = 1'b0;
    mem_ready = 1'b0;
    branch_taken = 1'b0;
    instrution_opcode = '0;
    @(posedge clk);
    #1;
    reset_pulse();

    do_instr(7'b0110011, 0, 0, 1'b0);
    do_instr(7'b0000011, 3, 3, 1'b0);
    do_instr(7'b0100011, 1, 2, 1'b0);
    do_instr(7'b1100011, 0, 0, 1'b1);
    do_instr(7'b1100011, 0, 0, 1'b0);
    do_instr(7'b1101111, 0, 0, 1'b0);
    do_instr(7'b1100111, 0, 0, 1'b0);
    do_instr(7'b0110111, 2, 0, 1'b0);
    do_instr(7'b0010111, 0, 0, 1'b0);
    do_instr(7'b0010011, 0, 0, 1'b0);
    do_instr(7'b0000011, 0, 0, 1'b0);
    do_instr(7'b0100011, 0, 0, 1'b0);

    for (int n = 0; n < 80; n++) begin
      opc = legal_ops[$urandom_range(0, 8)];
`ifndef ILLEGAL_TRAP_EN
      if ($urandom_range(0, 9) == 0) begin
        do opc = 7'($urandom); while (kind_of(opc) != K_BAD);
      end
`endif
      do_instr(opc, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    end

    // Asynchronous abort in the middle of an R-type EXEC cycle.
    fetch_phase(0);
    step("decode", decode_ctrl(), 1'b0, 7'b0110011, 1'b0);
    instrution_opcode = 7'b0110011;
    #1;
    e = '0; e.aluop = 2'b10;
    check_ctrl("exec_before_abort", e);
    rst_n = 1'b0;
    exp_instret = '0;
    #1;
    check_ctrl("async_abort", '0);
    check_instret("async_abort");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    boot_cycles();
    do_instr(7'b0110011, 0, 0, 1'b0);

    do_instr(7'b1111111, 0, 0, 1'b0);
`ifdef ILLEGAL_TRAP_EN
    reset_pulse();
`endif
    do_instr(7'b0110011, 1, 0, 1'b0);
    step("final_fetch", '{mem_read: 1'b1, a: 2'b10, b: 2'b10, default: '0}, 1'b0, 7'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
